info_frame_builder: RTL and testbench

INFO_FRAME_BUILDER -- requirements
Module: info_frame_builder

---
 rtl/hdmi_info_frame_pkg.sv | 17 +
 rtl/info_frame_checksum_acc.sv | 25 ++
 rtl/info_frame_builder.sv | 138 +++++++++++++
 tb/tb_info_frame_builder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_info_frame_pkg.sv
// Shared definitions for the HDMI InfoFrame builder: FSM states, type codes
// and payload size limit.
package hdmi_info_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_LOAD
  } build_state_t;

  localparam logic [6:0] IF_TYPE_AVI   = 7'd2;
  localparam logic [6:0] IF_TYPE_SPD   = 7'd3;
  localparam logic [6:0] IF_TYPE_AUDIO = 7'd4;

  localparam int unsigned MAX_PAYLOAD = 27;

endpackage

// File: rtl/info_frame_checksum_acc.sv
// Serial modulo-256 byte accumulator used to form the InfoFrame checksum.
module info_frame_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] result
);

  logic [7:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + data;
    end
  end

  assign result = acc;

endmodule

// File: rtl/info_frame_builder.sv
// Double-buffered InfoFrame builder: bytes land in a shadow buffer, a commit
// checksums them serially and publishes the result to the active buffer.
module info_frame_builder
  import hdmi_info_frame_pkg::*;
#(
  parameter logic [6:0] TYPE          = IF_TYPE_SPD,
  parameter logic [7:0] VERSION       = 8'd1,
  parameter logic [4:0] LENGTH        = 5'd25,
  parameter logic       ASCII0_AS_NUL = 1'b1
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  output logic             busy,
  output logic             write_err,
  output logic             frame_valid,
  output logic             updated,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub
);

  localparam logic [4:0]  LAST_IDX = LENGTH + 5'd2;
  localparam int unsigned LEN      = 32'(LENGTH);

  build_state_t state;
  logic [4:0]   idx;
  logic         pending;
  logic [7:0]   shadow [0:MAX_PAYLOAD];
  logic [7:0]   active [0:MAX_PAYLOAD];
  logic [7:0]   acc_sum;
  logic [7:0]   sum_byte;
  logic [7:0]   wr_byte;
  logic         wr_ok;
  logic         restart;
  logic         acc_clear;
  logic         acc_add;

  assign header  = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
  assign wr_ok   = wr_en && !busy && (wr_addr != 5'd0) && (wr_addr <= LENGTH);
  assign wr_byte = (ASCII0_AS_NUL && (wr_data == 8'h30)) ? 8'h00 : wr_data;
  assign restart = pending || commit;

  // The accumulator is cleared on the same edge the FSM (re)enters SUM.
  assign acc_clear = ((state == ST_IDLE) && commit) || ((state == ST_LOAD) && restart);
  assign acc_add   = (state == ST_SUM);

  always_comb begin
    sum_byte = '0;
    case (idx)
      5'd0:    sum_byte = header[23:16];
      5'd1:    sum_byte = header[15:8];
      5'd2:    sum_byte = header[7:0];
      default: sum_byte = shadow[idx - 5'd2];
    endcase
  end

  info_frame_checksum_acc u_acc (
    .clk    (clk_pixel),
    .rst    (reset),
    .clear  (acc_clear),
    .add    (acc_add),
    .data   (sum_byte),
    .result (acc_sum)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      write_err   <= 1'b0;
      updated     <= 1'b0;
      frame_valid <= 1'b0;
      for (int unsigned i = 0; i <= MAX_PAYLOAD; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      updated   <= 1'b0;
      write_err <= wr_en && !wr_ok;
      if (wr_ok) begin
        shadow[wr_addr] <= wr_byte;
      end
      case (state)
        ST_IDLE: begin
          if (commit) begin
            state <= ST_SUM;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        ST_SUM: begin
          if (commit) begin
            pending <= 1'b1;
          end
          idx <= idx + 5'd1;
          if (idx == LAST_IDX) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          active[0] <= 8'd0 - acc_sum;
          for (int unsigned i = 1; i <= MAX_PAYLOAD; i++) begin
            active[i] <= (i <= LEN) ? shadow[i] : 8'h00;
          end
          updated     <= 1'b1;
          frame_valid <= 1'b1;
          if (restart) begin
            state   <= ST_SUM;
            idx     <= '0;
            pending <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sub = '0;
    for (int unsigned g = 0; g < 4; g++) begin
      for (int unsigned k = 0; k < 7; k++) begin
        sub[g][8*k +: 8] = active[7*g + k];
      end
    end
  end

endmodule

// File: tb/tb_info_frame_builder.sv
// Self-checking bench for info_frame_builder with a payload-level reference model.
module tb_info_frame_builder;

  localparam int LEN = 25;
  localparam logic [7:0] HB0 = 8'h19;
  localparam logic [7:0] HB1 = 8'h01;
  localparam logic [7:0] HB2 = 8'h83;

  logic             clk_pixel = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [4:0]       wr_addr = '0;
  logic [7:0]       wr_data = '0;
  logic             commit = 1'b0;
  logic             busy;
  logic             write_err;
  logic             frame_valid;
  logic             updated;
  logic [23:0]      header;
  logic [3:0][55:0] sub;

  int compared = 0;
  int mismatched = 0;

  int model_pb [1:27];

  info_frame_builder #(
    .TYPE          (7'd3),
    .VERSION       (8'd1),
    .LENGTH        (5'd25),
    .ASCII0_AS_NUL (1'b1)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .busy        (busy),
    .write_err   (write_err),
    .frame_valid (frame_valid),
    .updated     (updated),
    .header      (header),
    .sub         (sub)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic int get_pb(input int n);
    return int'(sub[n / 7][8 * (n % 7) +: 8]);
  endfunction

  function automatic void model_clear();
    for (int i = 1; i <= 27; i++) model_pb[i] = 0;
  endfunction

  function automatic void model_write(input int addr, input int data);
    if (addr >= 1 && addr <= LEN) model_pb[addr] = (data == 'h30) ? 0 : data;
  endfunction

  // Expected published byte n: checksum for n=0, payload up to LENGTH, zero past it.
  function automatic int exp_pb(input int n);
    int s;
    if (n == 0) begin
      s = 'h19 + 'h01 + 'h83;
      for (int i = 1; i <= LEN; i++) s += model_pb[i];
      return (256 - (s % 256)) % 256;
    end
    return (n <= LEN) ? model_pb[n] : 0;
  endfunction

  task automatic wait_publish(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (updated) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic do_write(input int addr, input int data);
    wr_en = 1'b1;
    wr_addr = 5'(addr);
    wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if (header !== 24'h190183) begin
      mismatched++;
      $display("FAIL reset_header: got %h want 190183", header);
    end
    compared++;
    if ({busy, write_err, frame_valid, updated} !== 4'b0000 || sub !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got flags=%b sub=%h want 0", {busy, write_err, frame_valid, updated}, sub);
    end
    #2 reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_empty_commit();
    int cyc;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL empty_busy: got %b want 1", busy);
    end
    wait_publish(cyc);
    compared++;
    if (cyc != 29) begin
      mismatched++;
      $display("FAIL empty_latency: got %0d want 29", cyc);
    end
    compared++;
    if (get_pb(0) != 'h63 || frame_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL empty_pb0: got %h valid=%b want 63 valid=1", get_pb(0), frame_valid);
    end
    tick();
    compared++;
    if (updated !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL empty_pulse: got updated=%b busy=%b want 0 0", updated, busy);
    end
  endtask

  task automatic test_write_checksum();
    int cyc;
    do_write(1, 'h41);
    model_write(1, 'h41);
    compared++;
    if (write_err !== 1'b0) begin
      mismatched++;
      $display("FAIL wr_ok_err: got %b want 0", write_err);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_publish(cyc);
    compared++;
    if (get_pb(0) != 'h22 || sub[0][15:8] !== 8'h41 || cyc != 29) begin
      mismatched++;
      $display("FAIL pb1_checksum: got pb0=%h pb1=%h cyc=%0d want 22 41 29", get_pb(0), sub[0][15:8], cyc);
    end
    do_write(2, 'h30);
    model_write(2, 'h30);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_publish(cyc);
    compared++;
    if (sub[0][23:16] !== 8'h00 || get_pb(0) != exp_pb(0)) begin
      mismatched++;
      $display("FAIL ascii0_nul: got pb2=%h pb0=%h want 00 %h", sub[0][23:16], get_pb(0), exp_pb(0));
    end
  endtask

  task automatic test_write_errors();
    int cyc;
    do_write(0, 'h5a);
    compared++;
    if (write_err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_addr0: got %b want 1", write_err);
    end
    do_write(26, 'h5b);
    compared++;
    if (write_err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_addr26: got %b want 1", write_err);
    end
    tick();
    compared++;
    if (write_err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_one_cycle: got %b want 0", write_err);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    do_write(5, 'h77);
    compared++;
    if (write_err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_busy: got %b want 1", write_err);
    end
    wait_publish(cyc);
    compared++;
    if (cyc != 28) begin
      mismatched++;
      $display("FAIL err_latency: got %0d want 28", cyc);
    end
    for (int n = 0; n < 28; n++) begin
      compared++;
      if (get_pb(n) != exp_pb(n)) begin
        mismatched++;
        $display("FAIL err_shadow_pb%0d: got %h want %h", n, get_pb(n), exp_pb(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int second_at = -1;
    int gap = 0;
    do_write(7, 'h9c);
    model_write(7, 'h9c);
    commit = 1'b1;
    tick();
    for (int n = 1; n <= 100; n++) begin
      commit = (n == 3 || n == 5 || n == 7);
      tick();
      if (updated) begin
        pulses++;
        if (pulses == 2) second_at = n;
      end
      if (pulses == 1 && busy !== 1'b1) gap = 1;
    end
    commit = 1'b0;
    compared++;
    if (pulses != 2) begin
      mismatched++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
    compared++;
    if (second_at != 58 || gap != 0) begin
      mismatched++;
      $display("FAIL b2b_timing: got second=%0d gap=%0d want 58 0", second_at, gap);
    end
    compared++;
    if (busy !== 1'b0 || get_pb(0) != exp_pb(0) || get_pb(7) != 'h9c) begin
      mismatched++;
      $display("FAIL b2b_final: got busy=%b pb0=%h pb7=%h want 0 %h 9c", busy, get_pb(0), get_pb(7), exp_pb(0));
    end
  endtask

  task automatic test_mid_build_reset();
    int cyc;
    int saw_upd = 0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({busy, frame_valid, updated, write_err} !== 4'b0000 || sub !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got flags=%b sub=%h want 0", {busy, frame_valid, updated, write_err}, sub);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      if (updated) saw_upd = 1;
    end
    #2 reset = 1'b0;
    model_clear();
    for (int n = 0; n < 25; n++) begin
      tick();
      if (updated) saw_upd = 1;
    end
    compared++;
    if (saw_upd != 0 || frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_nopub: got upd=%0d valid=%b want 0 0", saw_upd, frame_valid);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_publish(cyc);
    compared++;
    if (cyc != 29 || get_pb(0) != 'h63 || header !== 24'h190183) begin
      mismatched++;
      $display("FAIL rst_mid_repub: got cyc=%0d pb0=%h hdr=%h want 29 63 190183", cyc, get_pb(0), header);
    end
  endtask

  task automatic test_random();
    int cyc;
    int addr;
    int data;
    int s;
    logic exp_err;
    for (int c = 0; c < 200; c++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        addr = int'($urandom_range(0, 27));
        data = ($urandom_range(0, 7) == 0) ? 'h30 : int'($urandom_range(0, 255));
        exp_err = (addr == 0 || addr > LEN);
        do_write(addr, data);
        model_write(addr, data);
        compared++;
        if (write_err !== exp_err) begin
          mismatched++;
          $display("FAIL rnd_wr_err c%0d a%0d: got %b want %b", c, addr, write_err, exp_err);
        end
      end
      commit = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        addr = int'($urandom_range(1, LEN));
        data = int'($urandom_range(0, 255));
        wr_addr = 5'(addr);
        wr_data = 8'(data);
        model_write(addr, data);
      end
      tick();
      commit = 1'b0;
      wr_en = 1'b0;
      wait_publish(cyc);
      compared++;
      if (cyc != 29) begin
        mismatched++;
        $display("FAIL rnd_latency c%0d: got %0d want 29", c, cyc);
      end
      s = 'h19 + 'h01 + 'h83;
      for (int n = 0; n < 28; n++) begin
        s += get_pb(n);
        compared++;
        if (get_pb(n) != exp_pb(n)) begin
          mismatched++;
          $display("FAIL rnd_pb%0d c%0d: got %h want %h", n, c, get_pb(n), exp_pb(n));
        end
      end
      compared++;
      if ((s % 256) != 0) begin
        mismatched++;
        $display("FAIL rnd_sum c%0d: got %0d want 0", c, s % 256);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_commit();
    test_write_checksum();
    test_write_errors();
    test_back_to_back();
    test_mid_build_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
